gemm_c_drain: RTL
=================

Name: gemm_c_drain

Overview:
Reader for the result SRAM that the GeMM accelerator writes. Each C word is one M×N output tile.
After a start pulse the block walks all tiles of the M_size×N_size result. It serialises the elements one per beat, in global row-major order, onto a valid/ready stream toward the host/DMA.
It uses the same tile addressing as the writer: addr = tile_m*(N_size/N) + tile_n, with element (r,c) of a tile at bits [(r*N+c)*OutDataWidth +: OutDataWidth].

Parameters:
OutDataWidth, 32, width of one C element and of the stream data.
AddrWidth, 16, SRAM C address width.
SizeAddrWidth, 8, width of the matrix size inputs.
M, 4, tile rows per SRAM word.
N, 4, tile columns per SRAM word.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
start_i  in  1  start pulse; sizes are sampled on the same edge.
M_size_i  in  SizeAddrWidth  result rows; a multiple of M.
N_size_i  in  SizeAddrWidth  result columns; a multiple of N.
sram_c_addr_o  out  AddrWidth  SRAM C read address.
sram_c_re_o  out  1  SRAM C read enable.
sram_c_rdata_i  in  OutDataWidth*M*N  SRAM C read data, valid the cycle after re.
m_data_o  out  OutDataWidth  stream element.
m_valid_o  out  1  stream valid.
m_ready_i  in  1  stream ready.
m_last_o  out  1  marks the final element of the matrix.
busy_o  out  1  high in any state other than IDLE.
done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values: all outputs 0; FSM in IDLE; all counters and the row buffer 0.
- Latched on start: MT = M_size_i/M and NT = N_size_i/N, each SizeAddrWidth wide.
- Counters:
  - tm: 0..MT-1, tile row.
  - r: 0..M-1, row within the tile.
  - tn: 0..NT-1, tile column.
  - col: 0..N-1, element within the row.
- States: IDLE, READ, WAIT, EMIT, DONE.
- IDLE:
  - start_i=1 latches MT and NT and clears the counters.
  - If MT==0 or NT==0, go to DONE; otherwise go to READ.
- READ:
  - sram_c_re_o=1 and sram_c_addr_o = tm*NT + tn, truncated to AddrWidth.
  - Lasts one cycle, then go to WAIT.
  - sram_c_addr_o holds its value outside READ; re is 0 outside READ.
- WAIT:
  - Latch row r of sram_c_rdata_i (N elements) into the row buffer.
  - Set col=0 and go to EMIT.
- EMIT:
  - m_valid_o=1 and m_data_o = buf[col].
  - A handshake is m_valid_o & m_ready_i; on a handshake col increments.
- End of a row (handshake with col==N-1), increments in priority order:
  - tn++.
  - If tn wraps: tn=0, r++.
  - If r wraps: r=0, tm++.
  - If tm wraps (final element), go to DONE; otherwise go to READ.
- m_last_o=1 only while EMIT presents the final element: tm==MT-1, r==M-1, tn==NT-1, col==N-1.
- Backpressure: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o are held stable and valid never drops. m_valid_o does not depend combinationally on m_ready_i.
- DONE: done_o=1 for exactly one cycle, then go to IDLE. busy_o=0 from IDLE onward.
- Each tile is re-read once per row (M reads per tile); no prefetch.
- Latency with ready held high:
  - start edge at cycle 0; READ in cycle 1; first valid in cycle 3.
  - Each row costs N+2 cycles.
  - Total before DONE: MT*M*NT*(N+2) cycles.
- start_i is ignored while busy_o=1, including in DONE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. A partially streamed matrix is abandoned and no done pulse is generated.
- Sizes that are not multiples of M/N: the remainder is truncated by integer division. No error is flagged.

Test Plan:
- M=N=4, sizes 4×4, tile element (r,c) = r*4+c, m_ready_i=1.
  - Four reads at addr 0.
  - 16 beats with values 0..15.
  - m_last_o only on beat 16.
  - done_o one cycle after the final handshake; 24 cycles from READ to DONE.
- Sizes 8×8, tile k filled with k*100 + r*4 + c.
  - Address sequence: 0,1 ×4 then 2,3 ×4.
  - Beat order row 0: 0..3, 100..103; row 4: 200..203, 300..303.
  - 64 beats total; m_last_o only on beat 64.
- 4×4 with m_ready_i toggling 1,0,0,1: every beat stays stable during stalls, no element is lost or duplicated, 16 handshakes.
- M_size_i=0 → done_o pulses the cycle after start; no re, no valid. Same result with N_size_i=0.
- Second start_i pulse mid-stream, with different sizes → ignored; the original 16-beat stream completes unchanged.
- rst_ni asserted after beat 5 → all outputs 0 immediately. A following start produces a full correct 16-beat stream from value 0.

Source files
------------

// File: rtl/gemm_c_drain.sv
// -----------------------------------------------------------------------------
// gemm_c_drain
//
// Reads the GeMM result SRAM (one M x N output tile per word) after a start
// pulse and streams every element of the M_size x N_size result, one per beat,
// in global row-major order on a valid/ready interface.
//
// Read order: for each tile row tm, for each row r inside the tile, for each
// tile column tn, the tile at tm*NT + tn is read and its row r is emitted.
// Each tile is therefore fetched once per row it contributes.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            start pulse; M_size_i / N_size_i sampled on the same edge
//   M_size_i, N_size_i result rows / columns (multiples of M / N, remainder dropped)
//   sram_c_addr_o      SRAM C read address (held between reads)
//   sram_c_re_o        SRAM C read enable (one cycle per row fetch)
//   sram_c_rdata_i     SRAM C read data, valid the cycle after the read enable
//   m_data_o           stream element
//   m_valid_o          stream valid
//   m_ready_i          stream ready
//   m_last_o           final element of the matrix
//   busy_o             high whenever the controller is not idle
//   done_o             one-cycle completion pulse
//
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module gemm_c_drain #(
    parameter int unsigned OutDataWidth  = 32,
    parameter int unsigned AddrWidth     = 16,
    parameter int unsigned SizeAddrWidth = 8,
    parameter int unsigned M             = 4,
    parameter int unsigned N             = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [SizeAddrWidth-1:0]        M_size_i,
    input  logic [SizeAddrWidth-1:0]        N_size_i,
    output logic [AddrWidth-1:0]            sram_c_addr_o,
    output logic                            sram_c_re_o,
    input  logic [OutDataWidth*M*N-1:0]     sram_c_rdata_i,
    output logic [OutDataWidth-1:0]         m_data_o,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic                            m_last_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned RowW  = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned ColW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ProdW = 2 * SizeAddrWidth + 1;

    typedef logic [SizeAddrWidth-1:0] size_t;
    typedef logic [RowW-1:0]          row_t;
    typedef logic [ColW-1:0]          col_t;

    localparam size_t SizeZero = SizeAddrWidth'(0);
    localparam size_t SizeOne  = SizeAddrWidth'(1);
    localparam size_t SizeM    = SizeAddrWidth'(M);
    localparam size_t SizeN    = SizeAddrWidth'(N);
    localparam row_t  RowZero  = RowW'(0);
    localparam row_t  RowOne   = RowW'(1);
    localparam row_t  RowLast  = RowW'(M - 1);
    localparam col_t  ColZero  = ColW'(0);
    localparam col_t  ColOne   = ColW'(1);
    localparam col_t  ColLast  = ColW'(N - 1);
    localparam logic [OutDataWidth-1:0] DataZero = OutDataWidth'(0);
    localparam logic [AddrWidth-1:0]    AddrZero = AddrWidth'(0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_WAIT = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Linear tile address; the product is formed wide and then cut to the
    // SRAM address width.
    function automatic logic [AddrWidth-1:0] tile_addr(
        input size_t tm,
        input size_t nt,
        input size_t tn
    );
        logic [ProdW-1:0] prod;
        prod = ProdW'(tm) * ProdW'(nt) + ProdW'(tn);
        return AddrWidth'(prod);
    endfunction

    // True when the counters point at the very last element of the matrix.
    function automatic logic is_final(
        input size_t tm,
        input size_t mt,
        input row_t  r,
        input size_t tn,
        input size_t nt,
        input col_t  col
    );
        return (tm == (mt - SizeOne)) && (r == RowLast) &&
               (tn == (nt - SizeOne)) && (col == ColLast);
    endfunction

    // Tile view of the read word: element (r,c) sits at flat index r*N+c.
    logic [M-1:0][N-1:0][OutDataWidth-1:0] tile_s;
    assign tile_s = sram_c_rdata_i;

    state_e                         state_q, state_d;
    size_t                          mt_q, mt_d;
    size_t                          nt_q, nt_d;
    size_t                          tm_q, tm_d;
    size_t                          tn_q, tn_d;
    row_t                           r_q, r_d;
    col_t                           col_q, col_d;
    logic [N-1:0][OutDataWidth-1:0] rowbuf_q, rowbuf_d;

    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic                    re_q, re_d;
    logic [OutDataWidth-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic handshake_s;
    logic tn_wrap_s;
    logic r_wrap_s;
    logic tm_wrap_s;

    // Wrap conditions of the nested row-end counters.
    always_comb begin
        handshake_s = valid_q & m_ready_i;
        tn_wrap_s   = (tn_q == (nt_q - SizeOne));
        r_wrap_s    = (r_q == RowLast);
        tm_wrap_s   = (tm_q == (mt_q - SizeOne));
    end

    // Next-state and counter logic of the drain controller.
    always_comb begin
        state_d  = state_q;
        mt_d     = mt_q;
        nt_d     = nt_q;
        tm_d     = tm_q;
        tn_d     = tn_q;
        r_d      = r_q;
        col_d    = col_q;
        rowbuf_d = rowbuf_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mt_d  = M_size_i / SizeM;
                    nt_d  = N_size_i / SizeN;
                    tm_d  = SizeZero;
                    tn_d  = SizeZero;
                    r_d   = RowZero;
                    col_d = ColZero;
                    if ((mt_d == SizeZero) || (nt_d == SizeZero)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Read data for the address issued in READ is present now.
                rowbuf_d = tile_s[r_q];
                col_d    = ColZero;
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (handshake_s) begin
                    if (col_q == ColLast) begin
                        col_d = ColZero;
                        if (tn_wrap_s) begin
                            tn_d = SizeZero;
                            if (r_wrap_s) begin
                                r_d = RowZero;
                                if (tm_wrap_s) begin
                                    tm_d    = SizeZero;
                                    state_d = S_DONE;
                                end else begin
                                    tm_d    = tm_q + SizeOne;
                                    state_d = S_READ;
                                end
                            end else begin
                                r_d     = r_q + RowOne;
                                state_d = S_READ;
                            end
                        end else begin
                            tn_d    = tn_q + SizeOne;
                            state_d = S_READ;
                        end
                    end else begin
                        col_d   = col_q + ColOne;
                        state_d = S_EMIT;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state so the
    // outputs can be registered without adding latency.
    always_comb begin
        re_d   = (state_d == S_READ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_READ) begin
            addr_d = tile_addr(tm_d, nt_d, tn_d);
        end else begin
            addr_d = addr_q;
        end
        valid_d = (state_d == S_EMIT);
        if (state_d == S_EMIT) begin
            data_d = rowbuf_d[col_d];
            last_d = is_final(tm_d, mt_d, r_d, tn_d, nt_d, col_d);
        end else begin
            data_d = DataZero;
            last_d = 1'b0;
        end
    end

    // State, counter, row buffer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            mt_q     <= SizeZero;
            nt_q     <= SizeZero;
            tm_q     <= SizeZero;
            tn_q     <= SizeZero;
            r_q      <= RowZero;
            col_q    <= ColZero;
            rowbuf_q <= '0;
            addr_q   <= AddrZero;
            re_q     <= 1'b0;
            data_q   <= DataZero;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mt_q     <= mt_d;
            nt_q     <= nt_d;
            tm_q     <= tm_d;
            tn_q     <= tn_d;
            r_q      <= r_d;
            col_q    <= col_d;
            rowbuf_q <= rowbuf_d;
            addr_q   <= addr_d;
            re_q     <= re_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sram_c_addr_o = addr_q;
    assign sram_c_re_o   = re_q;
    assign m_data_o      = data_q;
    assign m_valid_o     = valid_q;
    assign m_last_o      = last_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
